// File: rtl/sp_ram_multibank_pkg.sv
// Shared types and address-split helpers for the multibank single-port SRAM subsystem.
package sp_ram_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_e;

   localparam int unsigned BYTE_WIDTH = 8;
   localparam int unsigned BE_WIDTH_DEFAULT = 32 / BYTE_WIDTH;

   function automatic int unsigned be_width(input int unsigned dw);
      return dw / BYTE_WIDTH;
   endfunction

   function automatic int unsigned sel_width(input int unsigned nb);
      return (nb <= 1) ? 1 : $clog2(nb);
   endfunction

   function automatic int unsigned row_width(input int unsigned words);
      return (words <= 1) ? 1 : $clog2(words);
   endfunction

   function automatic logic [31:0] field_mask(input int unsigned w);
      return (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
   endfunction

   // Bank index from a byte address; bits above the bank/row field alias.
   function automatic int unsigned bank_index(input logic [31:0] addr, input int unsigned ofs_w,
                                              input int unsigned rw, input int unsigned sw,
                                              input logic il);
      logic [31:0] w;
      w = addr >> ofs_w;
      return il ? (w & field_mask(sw)) : ((w >> rw) & field_mask(sw));
   endfunction

   function automatic int unsigned row_index(input logic [31:0] addr, input int unsigned ofs_w,
                                             input int unsigned rw, input int unsigned sw,
                                             input logic il);
      logic [31:0] w;
      w = addr >> ofs_w;
      return il ? ((w >> sw) & field_mask(rw)) : (w & field_mask(rw));
   endfunction

endpackage

// File: rtl/sp_ram_multibank_if.sv
// Request/grant/rvalid bus between the interconnect and the multibank SRAM.
interface sp_ram_multibank_if
   import sp_ram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 18
) ();
   localparam int unsigned BE_W = be_width(DATA_WIDTH);

   logic                  req_i;
   logic                  gnt_o;
   logic                  we_i;
   logic [BE_W-1:0]       be_i;
   logic [ADDR_WIDTH-1:0] addr_i;
   logic [DATA_WIDTH-1:0] wdata_i;
   logic                  rvalid_o;
   logic [DATA_WIDTH-1:0] rdata_o;
   logic                  err_o;
   logic                  init_done_o;

   modport master (
      output req_i, we_i, be_i, addr_i, wdata_i,
      input  gnt_o, rvalid_o, rdata_o, err_o, init_done_o
   );

   modport slave (
      input  req_i, we_i, be_i, addr_i, wdata_i,
      output gnt_o, rvalid_o, rdata_o, err_o, init_done_o
   );
endinterface

// File: rtl/sp_ram_multibank_bank_macro.sv
// One SRAM hard-macro bank: active-high enable in, active-low chip/write/byte strobes inside.
module sp_ram_bank_macro
   import sp_ram_pkg::*;
#(
   parameter int unsigned WORDS      = 16384,
   parameter int unsigned DATA_WIDTH = 32,
   localparam int unsigned ROW_W     = row_width(WORDS),
   localparam int unsigned BE_W      = be_width(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [BE_W-1:0]       be,
   input  logic [ROW_W-1:0]      row,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic                  csn;
   logic                  wen;
   logic [BE_W-1:0]       bwen;
   logic                  test_mode;
   logic [DATA_WIDTH-1:0] mem [WORDS];
   logic [DATA_WIDTH-1:0] q;

   assign csn       = ~en;
   assign wen       = ~we;
   assign bwen      = ~be;
   assign test_mode = 1'b0;

   // Macro array: output holds its last read value, writes are byte-masked.
   always_ff @(posedge clk) begin
      if (!csn && !test_mode) begin
         if (!wen) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
               if (!bwen[i]) mem[row][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end else begin
            q <= mem[row];
         end
      end
   end

   assign rdata = q;
endmodule

// File: rtl/sp_ram_multibank.sv
// N-bank single-port SRAM behind one req/gnt/rvalid port; SP_RAM_INIT_EN adds a post-reset zeroing sweep.
module sp_ram_multibank
   import sp_ram_pkg::*;
#(
   parameter int unsigned NUM_BANKS  = 4,
   parameter int unsigned BANK_WORDS = 16384,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 18,
   parameter int unsigned INTERLEAVE = 0,
   parameter int unsigned OUT_REG    = 0
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   sp_ram_multibank_if.slave  bus
);
   localparam int unsigned BE_W  = be_width(DATA_WIDTH);
   localparam int unsigned OFS_W = (BE_W <= 1) ? 0 : $clog2(BE_W);
   localparam int unsigned RW    = row_width(BANK_WORDS);
   localparam int unsigned SW    = sel_width(NUM_BANKS);

   logic                  accept_c;
   logic                  rd_accept_c;
   logic                  oor_c;
   logic                  sweep_c;
   logic                  gnt_c;
   logic [SW-1:0]         bank_c;
   logic [RW-1:0]         row_c;
   logic [RW-1:0]         sweep_row_c;
   logic [NUM_BANKS-1:0]  bank_en_c;
   logic                  bank_we_c;
   logic [BE_W-1:0]       bank_be_c;
   logic [RW-1:0]         bank_row_c;
   logic [DATA_WIDTH-1:0] bank_wdata_c;
   logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
   logic                  rvalid_q;
   logic [SW-1:0]         rd_bank_q;
   logic                  rd_oor_q;
   logic [DATA_WIDTH-1:0] mux_c;

   assign bank_c = SW'(bank_index(32'(bus.addr_i), OFS_W, RW, SW, INTERLEAVE != 0));
   assign row_c  = RW'(row_index(32'(bus.addr_i), OFS_W, RW, SW, INTERLEAVE != 0));
   assign oor_c  = (32'(bank_c) >= NUM_BANKS);

   assign accept_c    = bus.req_i & gnt_c;
   assign rd_accept_c = accept_c & ~bus.we_i;

`ifdef SP_RAM_INIT_EN
   state_e        state_q, state_d;
   logic [RW-1:0] cnt_q, cnt_d;
   logic          gnt_q, gnt_d, done_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= INIT;
         cnt_q   <= '0;
         gnt_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         done_q  <= gnt_d;
      end
   end

   // Sweep one row per cycle; grant opens the cycle after the last row is written.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sweep_c = 1'b0;
      case (state_q)
         INIT: begin
            sweep_c = 1'b1;
            if (cnt_q == RW'(BANK_WORDS - 1)) begin
               state_d = READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + RW'(1);
            end
         end
         READY:   state_d = READY;
         default: state_d = INIT;
      endcase
      gnt_d = (state_d == READY);
   end

   assign sweep_row_c     = cnt_q;
   assign gnt_c           = gnt_q;
   assign bus.init_done_o = done_q;
`else
   assign sweep_c         = 1'b0;
   assign sweep_row_c     = '0;
   assign gnt_c           = 1'b1;
   assign bus.init_done_o = 1'b1;
`endif

   assign bus.gnt_o = gnt_c;

   // Shared macro inputs; the sweep overrides the port and enables every bank.
   always_comb begin
      bank_we_c    = sweep_c | bus.we_i;
      bank_be_c    = sweep_c ? '1 : bus.be_i;
      bank_row_c   = sweep_c ? sweep_row_c : row_c;
      bank_wdata_c = sweep_c ? '0 : bus.wdata_i;
      bank_en_c    = '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         bank_en_c[b] = sweep_c | (accept_c & ~oor_c & (bank_c == SW'(b)));
      end
   end

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      sp_ram_bank_macro #(
         .WORDS      (BANK_WORDS),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_bank (
         .clk   (clk_i),
         .en    (bank_en_c[g]),
         .we    (bank_we_c),
         .be    (bank_be_c),
         .row   (bank_row_c),
         .wdata (bank_wdata_c),
         .rdata (bank_rdata[g])
      );
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rvalid_q  <= 1'b0;
         rd_bank_q <= '0;
         rd_oor_q  <= 1'b0;
      end else begin
         rvalid_q <= rd_accept_c;
         if (rd_accept_c) begin
            rd_bank_q <= bank_c;
            rd_oor_q  <= oor_c;
         end
      end
   end

   always_comb begin
      mux_c = '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         if (rd_bank_q == SW'(b)) mux_c = bank_rdata[b];
      end
      if (rd_oor_q) mux_c = '0;
   end

   if (OUT_REG != 0) begin : g_oreg
      logic                  rvalid_r;
      logic [DATA_WIDTH-1:0] rdata_r;
      logic                  err_r;

      always_ff @(posedge clk_i or negedge rstn_i) begin
         if (!rstn_i) begin
            rvalid_r <= 1'b0;
            rdata_r  <= '0;
            err_r    <= 1'b0;
         end else begin
            rvalid_r <= rvalid_q;
            rdata_r  <= mux_c;
            err_r    <= rd_oor_q;
         end
      end

      assign bus.rvalid_o = rvalid_r;
      assign bus.rdata_o  = rdata_r;
      assign bus.err_o    = err_r;
   end else begin : g_noreg
      assign bus.rvalid_o = rvalid_q;
      assign bus.rdata_o  = mux_c;
      assign bus.err_o    = rd_oor_q;
   end
endmodule
